// File: rtl/seq_pkg.sv
// Shared types and helpers for the sequence-detector serial front end.
package seq_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam logic IDLE_BIT_DEFAULT = 1'b0;

    // Bit-counter width for a word of the given size (at least one bit).
    function automatic int unsigned CNT_W(input int unsigned width);
        return (width <= 1) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial converter feeding the sequence detector; a one-word hold
// buffer keeps the bit stream gapless across word boundaries.
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = IDLE_BIT_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_start,
    output logic             frame_last
);

    localparam int unsigned   CW         = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_IDX   = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PENULT_IDX = CW'(WIDTH - 2);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sreg_q;
    logic [WIDTH-1:0] hold_q;
    logic             hold_full_q, hold_full_d;
    logic             x_q, x_d;
    logic             xv_q, xv_d;
    logic             fs_q, fs_d;
    logic             fl_q, fl_d;

    logic             accept;
    logic             load_din;
    logic             load_hold;
    logic             do_shift;
    logic             hold_wr;

    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Bit that reaches the output end after one shift.
    function automatic logic next_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-2] : w[1];
    endfunction

    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign din_ready   = !rst && !hold_full_q;
    assign accept      = din_valid && din_ready;
    assign x           = x_q;
    assign x_valid     = xv_q;
    assign frame_start = fs_q;
    assign frame_last  = fl_q;

    // Next-state and registered-output decode.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        hold_full_d = hold_full_q;
        x_d         = x_q;
        xv_d        = xv_q;
        fs_d        = fs_q;
        fl_d        = fl_q;
        load_din    = 1'b0;
        load_hold   = 1'b0;
        do_shift    = 1'b0;
        hold_wr     = 1'b0;

        case (state_q)
            IDLE: begin
                x_d  = IDLE_BIT;
                xv_d = 1'b0;
                fs_d = 1'b0;
                fl_d = 1'b0;
                if (accept) begin
                    load_din = 1'b1;
                    cnt_d    = '0;
                    x_d      = first_bit(din);
                    xv_d     = 1'b1;
                    fs_d     = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q != LAST_IDX) begin
                    do_shift = 1'b1;
                    cnt_d    = cnt_q + CW'(1);
                    x_d      = next_bit(sreg_q);
                    fs_d     = 1'b0;
                    fl_d     = (cnt_q == PENULT_IDX);
                    if (accept) begin
                        hold_wr     = 1'b1;
                        hold_full_d = 1'b1;
                    end
                end else if (hold_full_q) begin
                    load_hold   = 1'b1;
                    hold_full_d = 1'b0;
                    cnt_d       = '0;
                    x_d         = first_bit(hold_q);
                    xv_d        = 1'b1;
                    fs_d        = 1'b1;
                    fl_d        = 1'b0;
                end else if (accept) begin
                    // Word arriving exactly on the boundary skips the hold buffer.
                    load_din = 1'b1;
                    cnt_d    = '0;
                    x_d      = first_bit(din);
                    xv_d     = 1'b1;
                    fs_d     = 1'b1;
                    fl_d     = 1'b0;
                end else begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    x_d     = IDLE_BIT;
                    xv_d    = 1'b0;
                    fs_d    = 1'b0;
                    fl_d    = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and serial output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= IDLE_BIT;
            xv_q    <= 1'b0;
            fs_q    <= 1'b0;
            fl_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            xv_q    <= xv_d;
            fs_q    <= fs_d;
            fl_q    <= fl_d;
        end
    end

    // Shift register holding the word currently on the wire.
    always_ff @(posedge clk) begin
        if (rst) begin
            sreg_q <= '0;
        end else if (load_din) begin
            sreg_q <= din;
        end else if (load_hold) begin
            sreg_q <= hold_q;
        end else if (do_shift) begin
            sreg_q <= shift_word(sreg_q);
        end
    end

    // One-word hold buffer; never overwritten since din_ready drops while full.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (hold_wr) begin
                hold_q <= din;
            end
            hold_full_q <= hold_full_d;
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Self-checking bench: per-cycle comparison against a word-schedule model plus
// literal checks on directed scenarios, for MSB-first and LSB-first instances.
module tb_seq_bit_serializer;

    localparam int unsigned W     = 8;
    localparam int          DEPTH = 1024;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] din0, din1;
    logic         v0, v1;
    logic         rdy0, x0, xv0, fs0, fl0;
    logic         rdy1, x1, xv1, fs1, fl1;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // Model schedule: expected outputs in the cycle after edge e, per instance.
    logic ex  [2][DEPTH];
    logic ev  [2][DEPTH];
    logic efs [2][DEPTH];
    logic efl [2][DEPTH];
    int   last_acc   [2];
    int   last_start [2];
    int   next_free  [2];

    // Observed history, indexed the same way.
    logic hx  [2][DEPTH];
    logic hv  [2][DEPTH];
    logic hfs [2][DEPTH];
    logic hfl [2][DEPTH];
    logic hr  [2][DEPTH];

    int e1, e2, e3, e4, e5, e6;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_msb (
        .clk(clk), .rst(rst), .din(din0), .din_valid(v0), .din_ready(rdy0),
        .x(x0), .x_valid(xv0), .frame_start(fs0), .frame_last(fl0)
    );

    seq_bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din1), .din_valid(v1), .din_ready(rdy1),
        .x(x1), .x_valid(xv1), .frame_start(fs1), .frame_last(fl1)
    );

    task automatic chk(input string name, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%b want=%b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    // A word is waiting if it was accepted before edge e but starts at or after e.
    function automatic logic model_ready(input int u, input int e, input logic r);
        return !r && !(last_acc[u] < e && last_start[u] >= e);
    endfunction

    task automatic model_edge(input int u, input int e, input logic r,
                              input logic v, input logic [W-1:0] d);
        int s;
        logic rdy;
        rdy = model_ready(u, e, r);
        if (r) begin
            for (int i = e; i < DEPTH; i++) begin
                ex[u][i] = 1'b0; ev[u][i] = 1'b0; efs[u][i] = 1'b0; efl[u][i] = 1'b0;
            end
            last_acc[u]   = -1;
            last_start[u] = -1;
            next_free[u]  = e + 1;
        end else if (v && rdy) begin
            s = (e > next_free[u]) ? e : next_free[u];
            for (int k = 0; k < int'(W); k++) begin
                if (s + k < DEPTH) begin
                    ex[u][s+k]  = (u == 0) ? d[int'(W) - 1 - k] : d[k];
                    ev[u][s+k]  = 1'b1;
                    efs[u][s+k] = (k == 0);
                    efl[u][s+k] = (k == int'(W) - 1);
                end
            end
            last_acc[u]   = e;
            last_start[u] = s;
            next_free[u]  = s + int'(W);
        end
    endtask

    function automatic logic [W-1:0] gather(input int u, input int e);
        logic [W-1:0] w;
        w = '0;
        for (int k = 0; k < int'(W); k++) w = {w[W-2:0], hx[u][e+k]};
        return w;
    endfunction

    // sel: 0 x_valid, 1 frame_start, 2 frame_last, 3 x
    function automatic int cnt(input int u, input int sel, input int e, input int n);
        int c;
        c = 0;
        for (int i = e; i < e + n; i++) begin
            case (sel)
                0:       c += int'(hv[u][i]);
                1:       c += int'(hfs[u][i]);
                2:       c += int'(hfl[u][i]);
                default: c += int'(hx[u][i]);
            endcase
        end
        return c;
    endfunction

    function automatic int run_valid(input int u, input int e);
        int c;
        c = 0;
        while (e + c < DEPTH && hv[u][e+c] === 1'b1) c++;
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Model update on every active edge.
    initial forever begin
        @(posedge clk);
        model_edge(0, cyc, rst, v0, din0);
        model_edge(1, cyc, rst, v1, din1);
        cyc = cyc + 1;
    end

    // Per-cycle compare against the model, away from the active edge.
    initial forever begin
        @(negedge clk);
        if (cyc >= 1 && cyc <= DEPTH) begin
            hx[0][cyc-1] = x0; hv[0][cyc-1] = xv0; hfs[0][cyc-1] = fs0; hfl[0][cyc-1] = fl0;
            hx[1][cyc-1] = x1; hv[1][cyc-1] = xv1; hfs[1][cyc-1] = fs1; hfl[1][cyc-1] = fl1;
            hr[0][cyc-1] = rdy0; hr[1][cyc-1] = rdy1;
            chk("msb_x",           x0,   ex[0][cyc-1]);
            chk("msb_x_valid",     xv0,  ev[0][cyc-1]);
            chk("msb_frame_start", fs0,  efs[0][cyc-1]);
            chk("msb_frame_last",  fl0,  efl[0][cyc-1]);
            chk("msb_din_ready",   rdy0, model_ready(0, cyc, rst));
            chk("lsb_x",           x1,   ex[1][cyc-1]);
            chk("lsb_x_valid",     xv1,  ev[1][cyc-1]);
            chk("lsb_frame_start", fs1,  efs[1][cyc-1]);
            chk("lsb_frame_last",  fl1,  efl[1][cyc-1]);
            chk("lsb_din_ready",   rdy1, model_ready(1, cyc, rst));
        end
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < DEPTH; i++) begin
                ex[u][i] = 1'b0; ev[u][i] = 1'b0; efs[u][i] = 1'b0; efl[u][i] = 1'b0;
                hx[u][i] = 1'b0; hv[u][i] = 1'b0; hfs[u][i] = 1'b0; hfl[u][i] = 1'b0;
                hr[u][i] = 1'b0;
            end
            last_acc[u] = -1; last_start[u] = -1; next_free[u] = 0;
        end
        rst = 1'b1; v0 = 1'b0; v1 = 1'b0; din0 = '0; din1 = '0;

        // Scenario 1: single word accepted at edge 2.
        step();
        step();
        rst = 1'b0; v0 = 1'b1; din0 = 8'b0011_0110;
        step();
        e1 = cyc - 1;
        v0 = 1'b0;
        repeat (10) step();
        chk_int("t1_accept_edge", e1, 2);
        chk_int("t1_word", int'(gather(0, e1)), 8'h36);
        chk("t1_first_start", hfs[0][e1], 1'b1);
        chk_int("t1_start_count", cnt(0, 1, e1, 10), 1);
        chk("t1_last_at_bit7", hfl[0][e1+7], 1'b1);
        chk_int("t1_last_count", cnt(0, 2, e1, 10), 1);
        chk("t1_idle_valid", hv[0][e1+8], 1'b0);
        chk("t1_idle_x", hx[0][e1+8], 1'b0);

        // Scenario 2: back-to-back words through the hold buffer.
        v0 = 1'b1; din0 = 8'hA5;
        step();
        e2 = cyc - 1;
        din0 = 8'h3C;
        step();
        v0 = 1'b0;
        repeat (20) step();
        chk_int("t2_run", run_valid(0, e2), 16);
        chk_int("t2_word0", int'(gather(0, e2)), 8'hA5);
        chk_int("t2_word1", int'(gather(0, e2 + 8)), 8'h3C);
        chk("t2_ready_low_first", hr[0][e2+1], 1'b0);
        chk("t2_ready_low_last", hr[0][e2+7], 1'b0);
        chk("t2_ready_back", hr[0][e2+8], 1'b1);
        chk("t2_second_start", hfs[0][e2+8], 1'b1);

        // Scenario 3: second word presented exactly on the boundary edge.
        v0 = 1'b1; din0 = 8'hFF;
        step();
        e3 = cyc - 1;
        v0 = 1'b0;
        repeat (7) step();
        v0 = 1'b1; din0 = 8'h00;
        step();
        v0 = 1'b0;
        repeat (12) step();
        chk_int("t3_word0", int'(gather(0, e3)), 8'hFF);
        chk_int("t3_word1", int'(gather(0, e3 + 8)), 8'h00);
        chk_int("t3_run", run_valid(0, e3), 16);
        chk("t3_bypass_start", hfs[0][e3+8], 1'b1);

        // Scenario 4: reset mid-word with a word waiting in hold.
        v0 = 1'b1; din0 = 8'hA5;
        step();
        e4 = cyc - 1;
        din0 = 8'h3C;
        step();
        v0 = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        repeat (20) step();
        chk("t4_bit3_valid", hv[0][e4+3], 1'b1);
        chk("t4_valid_after_rst", hv[0][e4+4], 1'b0);
        chk("t4_x_after_rst", hx[0][e4+4], 1'b0);
        chk("t4_ready_in_rst", hr[0][e4+4], 1'b0);
        chk("t4_ready_after_rst", hr[0][e4+5], 1'b1);
        chk_int("t4_no_held_word", cnt(0, 0, e4 + 4, 20), 0);

        // Scenario 5: LSB-first instance.
        v1 = 1'b1; din1 = 8'h01;
        step();
        e5 = cyc - 1;
        v1 = 1'b0;
        repeat (10) step();
        chk_int("t5_word", int'(gather(1, e5)), 8'h80);
        chk("t5_start", hfs[1][e5], 1'b1);
        chk("t5_last", hfl[1][e5+7], 1'b1);
        chk("t5_idle", hv[1][e5+8], 1'b0);

        // Scenario 6: idle stability after reset.
        rst = 1'b1;
        step();
        rst = 1'b0;
        e6 = cyc;
        repeat (20) step();
        for (int u = 0; u < 2; u++) begin
            chk_int("t6_valid", cnt(u, 0, e6, 20), 0);
            chk_int("t6_start", cnt(u, 1, e6, 20), 0);
            chk_int("t6_x", cnt(u, 3, e6, 20), 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
